// File: rtl/mac_arb_pkg.sv
// Shared types for the MAC datapath arbiter: operand bundle and response entry.
package mac_arb_pkg;
   localparam int OP_W      = 32;
   localparam int RES_W     = 64;
   // Wide enough for the largest supported requester count (8).
   localparam int TAG_MAX_W = 3;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic [OP_W-1:0] c;
      logic [OP_W-1:0] d;
      logic [OP_W-1:0] e;
   } mac_ops_t;

   typedef struct packed {
      logic [TAG_MAX_W-1:0] tag;
      logic [RES_W-1:0]     data;
   } mac_rsp_t;

   localparam int OPS_W = $bits(mac_ops_t);
endpackage

// File: rtl/mac_pipe_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// and ptr_nxt points just past the winner (holds when nothing is granted).
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic                 en,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] ptr_nxt
);
   localparam int PW = $clog2(N);

   int   idx;
   logic found;

   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_nxt    = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end
endmodule

// File: rtl/mac_pipe_arbiter.sv
// Shares one fixed-latency MAC datapath among NUM_REQ requesters; results are
// tagged through a shift register and buffered in a credit-protected FIFO.
module mac_pipe_arbiter
   import mac_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int PIPE_LAT  = 6,
   parameter int RSP_DEPTH = 8,
   parameter int TAG_W     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*OPS_W-1:0] req_ops,
   output logic [OP_W-1:0]          dp_a,
   output logic [OP_W-1:0]          dp_b,
   output logic [OP_W-1:0]          dp_c,
   output logic [OP_W-1:0]          dp_d,
   output logic [OP_W-1:0]          dp_e,
   input  logic [RES_W-1:0]         dp_y,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic [RES_W-1:0]         rsp_data,
   output logic                     busy
);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   logic [TAG_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant;
   logic               credit_ok, hs, pop, wr, full;
   logic [CNT_W-1:0]   credit_q, count_q, count_d;
   logic [OPS_W-1:0]   sel_ops;
   logic [TAG_W-1:0]   sel_tag;
   mac_ops_t           ops_q;
   logic [PIPE_LAT-1:0] vld_q;
   logic [TAG_W-1:0]   tag_q [PIPE_LAT];
   mac_rsp_t           mem_q [RSP_DEPTH];
   mac_rsp_t           wdata, head_q, head_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic               tag_unused;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit covers both in-flight slots and FIFO entries, so the FIFO can never overflow.
   assign credit_ok = credit_q < CNT_W'(RSP_DEPTH);

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (req_valid),
      .en      (credit_ok),
      .ptr     (ptr_q),
      .grant   (grant),
      .ptr_nxt (ptr_d)
   );

   assign req_ready = grant;
   assign hs        = |(req_valid & grant);

   always_comb begin
      sel_ops = '0;
      sel_tag = '0;
      for (int g = 0; g < NUM_REQ; g++) begin
         if (grant[g]) begin
            sel_ops = req_ops[g*OPS_W +: OPS_W];
            sel_tag = TAG_W'(g);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         ops_q    <= '0;
         vld_q    <= '0;
         credit_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         ops_q    <= hs ? mac_ops_t'(sel_ops) : '0;
         vld_q    <= {vld_q[PIPE_LAT-2:0], hs};
         credit_q <= credit_q + CNT_W'(hs) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      tag_q[0] <= sel_tag;
      for (int k = 1; k < PIPE_LAT; k++) tag_q[k] <= tag_q[k-1];
   end

   assign dp_a = ops_q.a;
   assign dp_b = ops_q.b;
   assign dp_c = ops_q.c;
   assign dp_d = ops_q.d;
   assign dp_e = ops_q.e;

   // Response FIFO: the head is kept in a register, bypassing a write into an empty slot.
   assign wr        = vld_q[PIPE_LAT-1];
   assign wdata     = {TAG_MAX_W'(tag_q[PIPE_LAT-1]), dp_y};
   assign rsp_valid = count_q != '0;
   assign pop       = rsp_valid && rsp_ready;
   assign full      = count_q == CNT_W'(RSP_DEPTH);
   assign wr_ptr_d  = wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
   assign rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   assign count_d   = count_q + CNT_W'(wr) - CNT_W'(pop);

   always_comb begin
      head_d = mem_q[rd_ptr_d];
      if (wr && (wr_ptr_q == rd_ptr_d)) head_d = wdata;
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign rsp_tag    = head_q.tag[TAG_W-1:0];
   assign rsp_data   = head_q.data;
   assign tag_unused = ^head_q.tag;
   assign busy       = (|vld_q) || (count_q != '0);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr && full));
endmodule

// File: tb/tb_mac_pipe_arbiter.sv
// Scoreboard bench for mac_pipe_arbiter with a behavioural MAC datapath model.
module tb_mac_pipe_arbiter;
   localparam int NREQ = 4;
   localparam int LAT  = 6;
   localparam int DEP  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_ready;
   logic [639:0]  req_ops = '0;
   logic [31:0]   dp_a, dp_b, dp_c, dp_d, dp_e;
   logic [63:0]   dp_y;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [1:0]    rsp_tag;
   logic [63:0]   rsp_data;
   logic          busy;

   typedef struct {
      logic [1:0]  tag;
      logic [63:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          hs_count = 0;
   int          rr_ptr = 0;
   int          cyc = 0;
   logic [159:0] mon_op;
   logic [63:0] dpipe [LAT-1] = '{default: '0};

   mac_pipe_arbiter #(.NUM_REQ(NREQ), .PIPE_LAT(LAT), .RSP_DEPTH(DEP), .TAG_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_ops(req_ops),
      .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_e(dp_e), .dp_y(dp_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mac_fn(input logic [31:0] a, b, c, d, e);
      return 64'(a) * 64'(b) + 64'(c) * (64'(d) + 64'(e));
   endfunction

   // Datapath model: result appears LAT cycles after the handshake that issued it.
   always @(posedge clk) begin
      dpipe[0] <= mac_fn(dp_a, dp_b, dp_c, dp_d, dp_e);
      for (int k = 1; k < LAT - 1; k++) dpipe[k] <= dpipe[k-1];
   end
   assign dp_y = dpipe[LAT-2];

   always @(negedge clk) begin
      if (rst_n) begin
         for (int g = 0; g < NREQ; g++) begin
            if (req_valid[g] && req_ready[g]) begin
               mon_op = req_ops[g*160 +: 160];
               sb_q.push_back('{tag: 2'(g), data: mac_fn(mon_op[159:128], mon_op[127:96],
                                  mon_op[95:64], mon_op[63:32], mon_op[31:0])});
               hs_count++;
            end
         end
      end
   end

   task automatic set_ops(input int g, input logic [31:0] a, b, c, d, e);
      req_ops[g*160 +: 160] = {a, b, c, d, e};
   endtask

   task automatic rand_ops();
      for (int g = 0; g < NREQ; g++)
         set_ops(g, $urandom, $urandom, $urandom, $urandom, $urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl rsp_valid=%b busy=%b req_ready=%b required 0 0 0000", rsp_valid, busy, req_ready);
      end
      n_tests++;
      if (rsp_tag !== 2'd0 || rsp_data !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_rsp tag=%0d data=%0h required 0 0", rsp_tag, rsp_data);
      end
      n_tests++;
      if ({dp_a, dp_b, dp_c, dp_d, dp_e} !== 160'd0) begin
         n_fail++;
         $display("FAIL reset_dp operands=%h required 0", {dp_a, dp_b, dp_c, dp_d, dp_e});
      end
      @(posedge clk); #1 rst_n = 1'b1;
      rr_ptr = 0;
   endtask

   task automatic test_single();
      int   hs_cyc;
      bit   seen;
      exp_t e;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      set_ops(2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7);
      req_valid = 4'b0100;
      @(negedge clk);
      hs_cyc = cyc;
      n_tests++;
      if (req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_grant req_ready=%b required 0100", req_ready);
      end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      n_tests++;
      if ({dp_a, dp_b, dp_c, dp_d, dp_e} !== {32'd3, 32'd4, 32'd5, 32'd6, 32'd7}) begin
         n_fail++;
         $display("FAIL single_dp operands=%h required 3,4,5,6,7", {dp_a, dp_b, dp_c, dp_d, dp_e});
      end
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1;
            n_tests++;
            if (cyc - hs_cyc != LAT + 1) begin
               n_fail++;
               $display("FAIL single_latency got=%0d required=%0d", cyc - hs_cyc, LAT + 1);
            end
            n_tests++;
            if (rsp_tag !== 2'd2 || rsp_data !== 64'd77) begin
               n_fail++;
               $display("FAIL single_rsp tag=%0d data=%0d required tag=2 data=77", rsp_tag, rsp_data);
            end
            if (sb_q.size() > 0) e = sb_q.pop_front();
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL single_timeout rsp_valid=0 required 1 within 20 cycles");
      end
      rr_ptr = 3;
   endtask

   task automatic test_round_robin();
      exp_t e;
      rsp_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         rand_ops();
         req_valid = 4'hF;
         @(negedge clk);
         n_tests++;
         if (req_ready !== (4'b0001 << rr_ptr)) begin
            n_fail++;
            $display("FAIL rr_grant step=%0d req_ready=%b required=%b", k, req_ready, 4'b0001 << rr_ptr);
         end
         rr_ptr = (rr_ptr + 1) % NREQ;
         if (rsp_valid && rsp_ready) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL rr_rsp unexpected tag=%0d data=%0h required none", rsp_tag, rsp_data);
            end else begin
               e = sb_q.pop_front();
               if (rsp_tag !== e.tag || rsp_data !== e.data) begin
                  n_fail++;
                  $display("FAIL rr_rsp tag=%0d data=%0h required tag=%0d data=%0h", rsp_tag, rsp_data, e.tag, e.data);
               end
            end
         end
      end
      @(posedge clk); #1 req_valid = '0;
      for (int k = 0; k < 30 && sb_q.size() > 0; k++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            n_tests++;
            e = sb_q.pop_front();
            if (rsp_tag !== e.tag || rsp_data !== e.data) begin
               n_fail++;
               $display("FAIL rr_drain tag=%0d data=%0h required tag=%0d data=%0h", rsp_tag, rsp_data, e.tag, e.data);
            end
         end
      end
      @(negedge clk);
      n_tests++;
      if (sb_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_idle pending=%0d busy=%b required 0 0", sb_q.size(), busy);
      end
   endtask

   task automatic test_backpressure();
      int   hs_before;
      exp_t e;
      hs_before = hs_count;
      rsp_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         rand_ops();
         req_valid = 4'hF;
         @(negedge clk);
         if (req_ready != 4'b0) begin
            n_tests++;
            if (req_ready !== (4'b0001 << rr_ptr)) begin
               n_fail++;
               $display("FAIL bp_grant req_ready=%b required=%b", req_ready, 4'b0001 << rr_ptr);
            end
            rr_ptr = (rr_ptr + 1) % NREQ;
         end
         if (rsp_valid && sb_q.size() > 0) begin
            n_tests++;
            if (rsp_tag !== sb_q[0].tag || rsp_data !== sb_q[0].data) begin
               n_fail++;
               $display("FAIL bp_hold tag=%0d data=%0h required tag=%0d data=%0h", rsp_tag, rsp_data, sb_q[0].tag, sb_q[0].data);
            end
         end
      end
      n_tests++;
      if (hs_count - hs_before != DEP || req_ready !== 4'b0 || rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_credit handshakes=%0d req_ready=%b rsp_valid=%b required 8 0000 1",
                  hs_count - hs_before, req_ready, rsp_valid);
      end
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         rand_ops();
         @(negedge clk);
         if (req_ready != 4'b0) begin
            n_tests++;
            if (req_ready !== (4'b0001 << rr_ptr)) begin
               n_fail++;
               $display("FAIL bp_resume_grant req_ready=%b required=%b", req_ready, 4'b0001 << rr_ptr);
            end
            rr_ptr = (rr_ptr + 1) % NREQ;
         end
         if (rsp_valid && rsp_ready) begin
            n_tests++;
            e = sb_q.pop_front();
            if (rsp_tag !== e.tag || rsp_data !== e.data) begin
               n_fail++;
               $display("FAIL bp_pop tag=%0d data=%0h required tag=%0d data=%0h", rsp_tag, rsp_data, e.tag, e.data);
            end
         end
      end
      n_tests++;
      if (hs_count - hs_before < 16) begin
         n_fail++;
         $display("FAIL bp_resume handshakes=%0d required at least 16", hs_count - hs_before);
      end
      @(posedge clk); #1 req_valid = '0;
      for (int k = 0; k < 40 && sb_q.size() > 0; k++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            n_tests++;
            e = sb_q.pop_front();
            if (rsp_tag !== e.tag || rsp_data !== e.data) begin
               n_fail++;
               $display("FAIL bp_drain tag=%0d data=%0h required tag=%0d data=%0h", rsp_tag, rsp_data, e.tag, e.data);
            end
         end
      end
      @(negedge clk);
      n_tests++;
      if (sb_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle pending=%0d busy=%b required 0 0", sb_q.size(), busy);
      end
   endtask

   task automatic test_reset_midflight();
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         set_ops(0, $urandom, $urandom, $urandom, $urandom, $urandom);
         req_valid = 4'b0001;
      end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_busy busy=%b required 1", busy);
      end
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      sb_q.delete();
      rr_ptr = 0;
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_tests++;
         if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stale cycle=%0d rsp_valid=%b required 0", k, rsp_valid);
         end
      end
   endtask

   task automatic test_fairness();
      int   exp_g[3] = '{3, 1, 3};
      exp_t e;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rand_ops();
      req_valid = 4'b0010;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL fair_setup req_ready=%b required 0010", req_ready);
      end
      @(posedge clk); #1 req_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (req_ready !== (4'b0001 << exp_g[k])) begin
            n_fail++;
            $display("FAIL fair_grant step=%0d req_ready=%b required=%b", k, req_ready, 4'b0001 << exp_g[k]);
         end
         @(posedge clk); #1 rand_ops();
      end
      req_valid = '0;
      for (int k = 0; k < 30 && sb_q.size() > 0; k++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            n_tests++;
            e = sb_q.pop_front();
            if (rsp_tag !== e.tag || rsp_data !== e.data) begin
               n_fail++;
               $display("FAIL fair_rsp tag=%0d data=%0h required tag=%0d data=%0h", rsp_tag, rsp_data, e.tag, e.data);
            end
         end
      end
      @(negedge clk);
      n_tests++;
      if (sb_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL fair_idle pending=%0d busy=%b required 0 0", sb_q.size(), busy);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_midflight();
      test_fairness();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
